pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It replaces the fixed-width, always-advancing inter-stage registers between the ID, EX, MEM and WB stages. Each instance carries a control field and a data field. The control field is forced to zero whenever the stage holds no valid beat, so a bubble never asserts RegWrite, MemWrite, Branch or similar. Because in_ready is registered, back-pressure from a stalled downstream stage does not form a combinational path through the pipeline.

---
 rtl/pipe_stage_skid.sv | 82 ++++++++
 tb/tb_pipe_stage_skid.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush.
// The control field reads as zero on bubbles. in_ready is registered, so there is no ready path back through the stage.
module pipe_stage_skid #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 133
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level
);

    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              main_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;
    logic              ready_q;
    logic              accept;
    logic              fire;

    assign accept = in_valid & ready_q;
    assign fire   = main_valid & out_ready;

    // ready_q always mirrors !skid_valid; both are updated on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl  <= '0;
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (flush) begin
            main_ctrl  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (skid_valid) begin
            if (fire) begin
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end
        end else if (main_valid) begin
            if (accept && fire) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (accept) begin
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
                skid_valid <= 1'b1;
                ready_q    <= 1'b0;
            end else if (fire) begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
            main_valid <= 1'b1;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    // The skid slot is only ever occupied while main is occupied.
    assign level     = {skid_valid, main_valid & ~skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: the queue holds exactly the beats the stage should be holding.
module tb_pipe_stage_skid;

    localparam int CW = 16;
    localparam int DW = 133;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    level;

    beat_t         q[$];
    logic [DW-1:0] last_data;
    int            total = 0;
    int            bad = 0;
    int            n_in = 0;
    int            n_out = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .level(level)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        chk("level", 160'(level), 160'(n));
        chk("out_valid", 160'(out_valid), 160'(n != 0));
        chk("in_ready", 160'(in_ready), 160'(n < 2));
        if (n != 0) begin
            chk("out_ctrl", 160'(out_ctrl), 160'(q[0].c));
            chk("out_data", 160'(out_data), 160'(q[0].d));
        end else begin
            chk("bubble_ctrl", 160'(out_ctrl), 160'(0));
            chk("hold_data", 160'(out_data), 160'(last_data));
        end
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic r, input logic f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        bit    acc;
        bit    fir;
        beat_t b;
        acc = in_valid && (q.size() < 2) && !flush;
        fir = (q.size() != 0) && out_ready;
        b.c = in_ctrl;
        b.d = in_data;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (fir) begin
                void'(q.pop_front());
                n_out++;
            end
            if (acc) begin
                q.push_back(b);
                n_in++;
            end
        end
        if (q.size() != 0) last_data = q[0].d;
        @(negedge clk);
        check_state();
    endtask

    initial begin
        int            start_in;
        int            start_out;
        int            cyc;
        logic [159:0]  rnd;

        rst = 1'b1;
        last_data = '0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_state();

        // streaming, one beat per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, CW'(i), DW'(i * 'h11), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();

        // stall and skid
        drive(1'b1, 16'h000A, DW'('hAA), 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h000B, DW'('hBB), 1'b0, 1'b0);
        step();
        chk("stall_level", 160'(level), 160'(2));
        chk("stall_ready", 160'(in_ready), 160'(0));
        chk("stall_hold_a", 160'(out_ctrl), 160'(16'h000A));
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        chk("skid_b_out", 160'(out_ctrl), 160'(16'h000B));
        step();
        chk("skid_drained", 160'(out_valid), 160'(0));

        // bubble gating
        drive(1'b1, 16'hFFFF, DW'('h5A5A), 1'b1, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        chk("bubble_ctrl0", 160'(out_ctrl), 160'(0));
        chk("bubble_data", 160'(out_data), 160'('h5A5A));

        // asynchronous reset while FULL
        drive(1'b1, 16'h0011, DW'('h111), 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0022, DW'('h222), 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 160'(out_valid), 160'(0));
        chk("rst_ctrl", 160'(out_ctrl), 160'(0));
        chk("rst_data", 160'(out_data), 160'(0));
        chk("rst_level", 160'(level), 160'(0));
        chk("rst_ready", 160'(in_ready), 160'(1));
        q.delete();
        last_data = '0;
        @(negedge clk);
        rst = 1'b0;
        check_state();

        // flush while FULL, with a beat offered in the same cycle
        drive(1'b1, 16'h0031, DW'('h31), 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0032, DW'('h32), 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h00C3, DW'('hC3), 1'b0, 1'b1);
        step();
        chk("flush_level", 160'(level), 160'(0));
        chk("flush_ready", 160'(in_ready), 160'(1));
        chk("flush_ctrl", 160'(out_ctrl), 160'(0));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) step();

        // randomised valid/ready
        start_in  = n_in;
        start_out = n_out;
        cyc = 0;
        while ((n_in - start_in) < 1000 && cyc < 20000) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 99) < 65), CW'($urandom), rnd[DW-1:0],
                  1'($urandom_range(0, 99) < 60), 1'b0);
            step();
            cyc++;
        end
        chk("rand_accepted", 160'(n_in - start_in), 160'(1000));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (4) step();
        chk("rand_drain_level", 160'(level), 160'(0));
        chk("rand_delivered", 160'(n_out - start_out), 160'(1000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
